// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external SRAM-like burst port between I-cache refill (I) and
//   D-cache refill/writeback/uncached access (D). One burst outstanding at a time.
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     i_req/i_addr/i_len                I read request (held until i_addr_ok)
//     i_addr_ok/i_data_ok/i_rdata       I handshakes and read data
//     d_req/d_wr/d_addr/d_len/d_wstrb   D request (held until d_addr_ok)
//     d_wdata                           current D write beat
//     d_addr_ok/d_data_ok/d_rdata       D handshakes and read data
//     m_req/m_wr/m_addr/m_len/m_wstrb   request to slave
//     m_wdata                           write beat to slave
//     m_addr_ok/m_data_ok/m_rdata/m_last slave handshakes, data, last-beat flag
//     owner                             00 none, 01 I, 10 D
//     proto_err                         sticky slave protocol violation
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [LEN_W-1:0]    i_len,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_wr,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [LEN_W-1:0]    d_len,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_wr,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [LEN_W-1:0]    m_len,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_last,
    output logic [1:0]          owner,
    output logic                proto_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state, state_nx;
    logic [1:0]            owner_q;
    logic                  wr_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [LEN_W-1:0]      len_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [LEN_W-1:0]      beat;
    logic [SW-1:0]         starve;
    logic                  grant_i, grant_d;
    logic                  last_beat, beat_fire;

    assign last_beat = (beat == len_q);
    assign beat_fire = (state == DATA) && m_data_ok;

    // D has priority unless I has waited through STARVE_MAX D grants.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_req && (starve == STARVE_TOP)) grant_i = 1'b1;
            else if (d_req)                      grant_d = 1'b1;
            else if (i_req)                      grant_i = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_i || grant_d)     state_nx = ADDR;
            ADDR:    if (m_addr_ok)              state_nx = DATA;
            DATA:    if (beat_fire && last_beat) state_nx = IDLE;
            default:                             state_nx = IDLE;
        endcase
    end

    // Request capture, beat/starve counters, protocol checker
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= OWN_NONE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wstrb_q   <= '0;
            beat      <= '0;
            starve    <= '0;
            proto_err <= 1'b0;
        end else begin
            if (grant_i) begin
                owner_q <= OWN_I;
                wr_q    <= 1'b0;
                addr_q  <= i_addr;
                len_q   <= i_len;
                wstrb_q <= '0;
                beat    <= '0;
            end else if (grant_d) begin
                owner_q <= OWN_D;
                wr_q    <= d_wr;
                addr_q  <= d_addr;
                len_q   <= d_len;
                wstrb_q <= d_wstrb;
                beat    <= '0;
            end else if (beat_fire) begin
                beat <= beat + 1'b1;
            end

            if (state == IDLE) begin
                if (!i_req || grant_i)
                    starve <= '0;
                else if (grant_d && (starve != STARVE_TOP))
                    starve <= starve + 1'b1;
            end

            if ((m_data_ok && (state != DATA)) ||
                (m_addr_ok && (state != ADDR)) ||
                (beat_fire && (m_last != last_beat)))
                proto_err <= 1'b1;
        end
    end

    // Outputs: handshakes routed to the owner; all strobes held low during reset
    always_comb begin
        m_req     = 1'b0;
        owner     = OWN_NONE;
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;
        if (!rst && (state != IDLE)) begin
            owner = owner_q;
            if (state == ADDR) begin
                m_req     = 1'b1;
                i_addr_ok = m_addr_ok && (owner_q == OWN_I);
                d_addr_ok = m_addr_ok && (owner_q == OWN_D);
            end
            if (state == DATA) begin
                i_data_ok = m_data_ok && (owner_q == OWN_I);
                d_data_ok = m_data_ok && (owner_q == OWN_D);
            end
        end
    end

    assign m_wr    = wr_q;
    assign m_addr  = addr_q;
    assign m_len   = len_q;
    assign m_wstrb = wstrb_q;
    assign m_wdata = d_wdata;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. The bench plays both cache
//   requesters and the slave; every beat it drives is pushed to a scoreboard
//   and popped when the arbiter routes it to a requester.
module tb_mem_port_arbiter;

    localparam logic [1:0] WHO_N = 2'b00;
    localparam logic [1:0] WHO_I = 2'b01;
    localparam logic [1:0] WHO_D = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_addr_ok, i_data_ok;
    logic [31:0] i_addr, i_rdata;
    logic [3:0]  i_len;
    logic        d_req, d_wr, d_addr_ok, d_data_ok;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_len, d_wstrb;
    logic        m_req, m_wr, m_addr_ok, m_data_ok, m_last;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_len, m_wstrb;
    logic [1:0]  owner;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  who;
        logic        wr;
        logic [31:0] data;
    } beat_t;
    beat_t sbq[$];

    typedef struct {
        logic       ir;
        logic       dr;
        logic       dw;
        logic [1:0] who;
    } vec_t;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(4), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_len(d_len),
        .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_len(m_len),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .m_last(m_last), .owner(owner), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat monitor: every routed beat must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && (i_data_ok || d_data_ok)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_beat", {i_data_ok, d_data_ok}, 2'b00);
            end else begin
                beat_t e;
                e = sbq.pop_front();
                chk("beat_route", {i_data_ok, d_data_ok}, (e.who == WHO_I) ? 2'b10 : 2'b01);
                if (e.wr) chk("wdata", m_wdata, e.data);
                else      chk("rdata", (e.who == WHO_I) ? i_rdata : d_rdata, e.data);
            end
        end
    end

    // Acts as slave for one burst: waits for m_req, accepts address one cycle
    // later, then returns nbeats beats with m_last on beat index last_at.
    task automatic serve(input logic [1:0] who, input int nbeats, input int last_at,
                         input int exp_wait, input logic wr);
        int w = 0;
        beat_t e;
        @(negedge clk);
        while (!m_req && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!m_req) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=0 required=1");
            return;
        end
        chk("req_latency", w, exp_wait);
        chk("grant_owner", owner, who);
        chk("m_addr", m_addr, (who == WHO_I) ? i_addr : d_addr);
        chk("m_len", m_len, nbeats - 1);
        if (who == WHO_D) begin
            chk("m_wr", m_wr, wr);
            if (wr) chk("m_wstrb", m_wstrb, d_wstrb);
        end
        tick();
        m_addr_ok = 1'b1;
        @(negedge clk);
        chk("addr_ok_route", {i_addr_ok, d_addr_ok}, (who == WHO_I) ? 2'b10 : 2'b01);
        tick();
        m_addr_ok = 1'b0;
        if (who == WHO_I) i_req = 1'b0;
        else              d_req = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            m_data_ok = 1'b1;
            m_rdata   = $urandom;
            m_last    = (b == last_at);
            if (wr) d_wdata = $urandom;
            e.who  = who;
            e.wr   = wr;
            e.data = wr ? d_wdata : m_rdata;
            sbq.push_back(e);
            tick();
        end
        m_data_ok = 1'b0;
        m_last    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        int   t;
        vt[0] = '{ir: 1'b1, dr: 1'b0, dw: 1'b0, who: WHO_I};
        vt[1] = '{ir: 1'b0, dr: 1'b1, dw: 1'b1, who: WHO_D};
        vt[2] = '{ir: 1'b1, dr: 1'b1, dw: 1'b0, who: WHO_D};
        vt[3] = '{ir: 1'b0, dr: 1'b0, dw: 1'b0, who: WHO_N};
        vt[4] = '{ir: 1'b1, dr: 1'b1, dw: 1'b1, who: WHO_D};

        rst = 1'b1;
        i_req = 0; i_addr = 0; i_len = 0;
        d_req = 0; d_wr = 0; d_addr = 0; d_len = 0; d_wstrb = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0; m_last = 0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_m_req", m_req, 1'b0);
        chk("reset_owner", owner, WHO_N);
        chk("reset_proto_err", proto_err, 1'b0);
        tick();

        // 1: I-only 4-beat burst
        i_addr = 32'h0000_1000; i_len = 4'd3; i_req = 1'b1;
        serve(WHO_I, 4, 3, 1, 1'b0);
        @(negedge clk);
        chk("t1_owner_idle", owner, WHO_N);
        chk("t1_proto_err", proto_err, 1'b0);
        tick();

        // arbitration table: single-beat bursts
        foreach (vt[k]) begin
            i_addr = $urandom; d_addr = $urandom; i_len = 0; d_len = 0;
            d_wr = vt[k].dw; d_wstrb = 4'h5;
            i_req = vt[k].ir; d_req = vt[k].dr;
            if (vt[k].who == WHO_N) begin
                @(negedge clk);
                @(negedge clk);
                chk("vec_idle_m_req", m_req, 1'b0);
                chk("vec_idle_owner", owner, WHO_N);
                tick();
            end else begin
                serve(vt[k].who, 1, 0, 1, (vt[k].who == WHO_D) ? vt[k].dw : 1'b0);
            end
            i_req = 1'b0; d_req = 1'b0;
            tick();
        end

        // 2: simultaneous requests, D first then I after the IDLE bubble
        i_addr = 32'h2000; i_len = 4'd1; d_addr = 32'h3000; d_len = 4'd1;
        d_wr = 1'b1; d_wstrb = 4'hC;
        i_req = 1'b1; d_req = 1'b1;
        serve(WHO_D, 2, 1, 1, 1'b1);
        serve(WHO_I, 2, 1, 1, 1'b0);
        tick();

        // 3: starvation limit -> D,D,D,D,I,D
        i_len = 0; d_len = 0; d_wr = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int n = 0; n < 4; n++) begin
            serve(WHO_D, 1, 0, 1, 1'b0);
            d_req = 1'b1;
        end
        serve(WHO_I, 1, 0, 1, 1'b0);
        serve(WHO_D, 1, 0, 1, 1'b0);
        tick();

        // 4: D write burst, wdata follows d_wdata
        d_addr = 32'h4000; d_len = 4'd1; d_wr = 1'b1; d_wstrb = 4'hF; d_req = 1'b1;
        serve(WHO_D, 2, 1, 1, 1'b1);
        @(negedge clk);
        chk("t4_proto_err", proto_err, 1'b0);
        tick();

        // 5: early m_last -> sticky proto_err, burst still 4 beats
        i_addr = 32'h5000; i_len = 4'd3; i_req = 1'b1;
        serve(WHO_I, 4, 1, 1, 1'b0);
        @(negedge clk);
        chk("t5_idle_after_4", owner, WHO_N);
        chk("t5_proto_err", proto_err, 1'b1);
        tick();
        tick();
        @(negedge clk);
        chk("t5_proto_sticky", proto_err, 1'b1);
        tick();

        // 6: reset mid-burst
        i_addr = 32'h6000; i_len = 4'd3; i_req = 1'b1;
        t = 0;
        @(negedge clk);
        while (!m_req && t < 50) begin
            t++;
            @(negedge clk);
        end
        chk("t6_m_req", m_req, 1'b1);
        tick();
        m_addr_ok = 1'b1;
        tick();
        begin
            beat_t e;
            m_addr_ok = 1'b0; i_req = 1'b0;
            m_data_ok = 1'b1; m_rdata = $urandom; m_last = 1'b0;
            e.who = WHO_I; e.wr = 1'b0; e.data = m_rdata;
            sbq.push_back(e);
        end
        tick();
        rst = 1'b1;
        m_rdata = $urandom;
        @(negedge clk);
        chk("t6_rst_m_req", m_req, 1'b0);
        chk("t6_rst_data_ok", {i_data_ok, d_data_ok}, 2'b00);
        tick();
        rst = 1'b0; m_data_ok = 1'b0;
        @(negedge clk);
        chk("t6_post_m_req", m_req, 1'b0);
        chk("t6_post_owner", owner, WHO_N);
        chk("t6_post_proto_err", proto_err, 1'b0);
        tick();
        i_addr = 32'h7000; i_len = 4'd2; i_req = 1'b1;
        serve(WHO_I, 3, 2, 1, 1'b0);
        @(negedge clk);
        chk("t6_fresh_proto_err", proto_err, 1'b0);
        tick();

        // stray beat in IDLE: ignored but flagged
        m_data_ok = 1'b1; m_rdata = $urandom;
        @(negedge clk);
        chk("stray_data_ok", {i_data_ok, d_data_ok}, 2'b00);
        tick();
        m_data_ok = 1'b0;
        @(negedge clk);
        chk("stray_proto_err", proto_err, 1'b1);
        chk("stray_m_req", m_req, 1'b0);
        tick();

        chk("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
